lzw_dict_table: RTL and testbench

Parametrised LZW dictionary store for the compressor/decompressor datapath. Holds one prefix-code/append-character pair per assigned code. Owns the next-free-code counter, so callers no longer manage the write address. Provides:
- an add port with a valid/ready handshake;
- a 1-cycle registered read port that also decodes root codes;
- a flush that resets the dictionary;
- a full flag for the code-width controller.

---
 rtl/lzw_dict_table.sv | 128 ++++++++++++
 tb/tb_lzw_dict_table.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_dict_table.sv
// LZW dictionary store: prefix/char arrays, next-free-code counter, full flag, 1-cycle read.
// Optional `define LZW_DICT_BYPASS_EN forwards a same-cycle add to a read of next_code (KwKwK).
module lzw_dict_table #(
  parameter int CODE_W     = 13,
  parameter int CHAR_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int FIRST_CODE = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              add_valid,
  output logic              add_ready,
  input  logic [CODE_W-1:0] add_prefix,
  input  logic [CHAR_W-1:0] add_char,
  output logic [CODE_W-1:0] next_code,
  output logic              full,
  input  logic              rd_req,
  input  logic [CODE_W-1:0] rd_code,
  output logic              rd_valid,
  output logic [CODE_W-1:0] rd_prefix,
  output logic [CHAR_W-1:0] rd_char,
  output logic              rd_root,
  output logic              rd_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CODE_W-1:0] FIRST = CODE_W'(FIRST_CODE);
  localparam logic [CODE_W-1:0] LAST  = CODE_W'(DEPTH - 1);

  logic [CODE_W-1:0] prefix_mem [DEPTH];
  logic [CHAR_W-1:0] char_mem   [DEPTH];

  logic [CODE_W-1:0] next_code_reg, next_code_next;
  logic              full_reg, full_next;
  logic              add_fire;

  logic [CODE_W-1:0] mem_prefix_reg;
  logic [CHAR_W-1:0] mem_char_reg;
  logic              use_mem_reg, use_mem_next;
  logic [CODE_W-1:0] alt_prefix_reg, alt_prefix_next;
  logic [CHAR_W-1:0] alt_char_reg, alt_char_next;
  logic              rd_root_reg, rd_root_next;
  logic              rd_err_reg, rd_err_next;
  logic              rd_valid_reg;

  assign add_ready = !full_reg && !flush;
  assign add_fire  = add_valid && add_ready;

  always_comb begin
    next_code_next = next_code_reg;
    full_next      = full_reg;
    if (flush) begin
      next_code_next = FIRST;
      full_next      = 1'b0;
    end else if (add_fire) begin
      next_code_next = next_code_reg + CODE_W'(1);
      full_next      = (next_code_reg == LAST);
    end
  end

  // Classification uses next_code before any same-cycle increment or flush.
  always_comb begin
    use_mem_next    = 1'b0;
    alt_prefix_next = '0;
    alt_char_next   = '0;
    rd_root_next    = 1'b0;
    rd_err_next     = 1'b0;
    if (rd_code < FIRST) begin
      rd_root_next  = 1'b1;
      alt_char_next = rd_code[CHAR_W-1:0];
    end else if (rd_code < next_code_reg) begin
      use_mem_next = 1'b1;
`ifdef LZW_DICT_BYPASS_EN
    end else if (add_fire && (rd_code == next_code_reg)) begin
      alt_prefix_next = add_prefix;
      alt_char_next   = add_char;
`endif
    end else begin
      rd_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_code_reg  <= FIRST;
      full_reg       <= 1'b0;
      rd_valid_reg   <= 1'b0;
      use_mem_reg    <= 1'b0;
      alt_prefix_reg <= '0;
      alt_char_reg   <= '0;
      rd_root_reg    <= 1'b0;
      rd_err_reg     <= 1'b0;
    end else begin
      next_code_reg <= next_code_next;
      full_reg      <= full_next;
      rd_valid_reg  <= rd_req;
      if (rd_req) begin
        use_mem_reg    <= use_mem_next;
        alt_prefix_reg <= alt_prefix_next;
        alt_char_reg   <= alt_char_next;
        rd_root_reg    <= rd_root_next;
        rd_err_reg     <= rd_err_next;
      end
    end
  end

  // Block-RAM style arrays: no reset, registered read; the select flag masks stale data.
  always_ff @(posedge clk) begin
    if (add_fire) begin
      prefix_mem[next_code_reg[ADDR_W-1:0]] <= add_prefix;
      char_mem[next_code_reg[ADDR_W-1:0]]   <= add_char;
    end
    if (rd_req) begin
      mem_prefix_reg <= prefix_mem[rd_code[ADDR_W-1:0]];
      mem_char_reg   <= char_mem[rd_code[ADDR_W-1:0]];
    end
  end

  assign next_code = next_code_reg;
  assign full      = full_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_prefix = use_mem_reg ? mem_prefix_reg : alt_prefix_reg;
  assign rd_char   = use_mem_reg ? mem_char_reg : alt_char_reg;
  assign rd_root   = rd_root_reg;
  assign rd_err    = rd_err_reg;

endmodule

// File: tb/tb_lzw_dict_table.sv
// Scoreboard bench for lzw_dict_table: driver pushes expected read responses, monitor pops and compares.
module tb_lzw_dict_table;
  localparam int CODE_W = 13;
  localparam int CHAR_W = 8;
  localparam int ADDR_W = 9;
  localparam int FIRST  = 256;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              add_valid = 1'b0;
  logic              add_ready;
  logic [CODE_W-1:0] add_prefix = '0;
  logic [CHAR_W-1:0] add_char = '0;
  logic [CODE_W-1:0] next_code;
  logic              full;
  logic              rd_req = 1'b0;
  logic [CODE_W-1:0] rd_code = '0;
  logic              rd_valid;
  logic [CODE_W-1:0] rd_prefix;
  logic [CHAR_W-1:0] rd_char;
  logic              rd_root;
  logic              rd_err;

  lzw_dict_table #(.CODE_W(CODE_W), .CHAR_W(CHAR_W), .ADDR_W(ADDR_W), .FIRST_CODE(FIRST)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .add_valid(add_valid), .add_ready(add_ready), .add_prefix(add_prefix), .add_char(add_char),
    .next_code(next_code), .full(full),
    .rd_req(rd_req), .rd_code(rd_code), .rd_valid(rd_valid),
    .rd_prefix(rd_prefix), .rd_char(rd_char), .rd_root(rd_root), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int prefix;
    int chr;
    int root;
    int err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference dictionary indexed by code value
  int ref_prefix [DEPTH];
  int ref_char   [DEPTH];
  int ref_next = FIRST;
  int ref_full = 0;
  int last_prefix = 0, last_char = 0, last_root = 0, last_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit fl, input bit av, input int ap, input int ac,
                      input bit rq, input int rc);
    exp_t e;
    bit acc;
    @(negedge clk);
    chk("next_code", int'(next_code), ref_next);
    chk("full", int'(full), ref_full);
    flush      = fl;
    add_valid  = av;
    add_prefix = CODE_W'(ap);
    add_char   = CHAR_W'(ac);
    rd_req     = rq;
    rd_code    = CODE_W'(rc);
    #1;
    chk("add_ready", int'(add_ready), (ref_full == 0 && !fl) ? 1 : 0);
    acc = av && (ref_full == 0) && !fl;
    if (rq) begin
      e.code = rc; e.prefix = 0; e.chr = 0; e.root = 0; e.err = 0;
      if (rc < FIRST) begin
        e.root = 1;
        e.chr  = rc % 256;
      end else if (rc < ref_next) begin
        e.prefix = ref_prefix[rc];
        e.chr    = ref_char[rc];
`ifdef LZW_DICT_BYPASS_EN
      end else if (acc && rc == ref_next) begin
        e.prefix = ap;
        e.chr    = ac;
`endif
      end else begin
        e.err = 1;
      end
      expq.push_back(e);
    end
    if (fl) begin
      ref_next = FIRST;
      ref_full = 0;
    end else if (acc) begin
      ref_prefix[ref_next] = ap;
      ref_char[ref_next]   = ac;
      ref_next++;
      ref_full = (ref_next == DEPTH) ? 1 : 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per rd_valid, checks hold otherwise
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (rd_valid) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid actual=1 required=0 t=%0t", $time);
          end else begin
            e = expq.pop_front();
            chk("rd_prefix", int'(rd_prefix), e.prefix);
            chk("rd_char", int'(rd_char), e.chr);
            chk("rd_root", int'(rd_root), e.root);
            chk("rd_err", int'(rd_err), e.err);
            $display("rd code=%0d prefix=%0d char=%0d root=%0d err=%0d", e.code,
                     rd_prefix, rd_char, rd_root, rd_err);
            last_prefix = e.prefix; last_char = e.chr; last_root = e.root; last_err = e.err;
          end
        end else begin
          chk("hold_prefix", int'(rd_prefix), last_prefix);
          chk("hold_char", int'(rd_char), last_char);
          chk("hold_root", int'(rd_root), last_root);
          chk("hold_err", int'(rd_err), last_err);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, sel;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_prefix", int'(rd_prefix), 0);
    chk("rst_rd_char", int'(rd_char), 0);
    chk("rst_rd_root", int'(rd_root), 0);
    chk("rst_rd_err", int'(rd_err), 0);
    chk("rst_next_code", int'(next_code), FIRST);
    chk("rst_full", int'(full), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic adds and reads
    step(0, 1, 65, 'h42, 0, 0);
    step(0, 1, 256, 'h43, 0, 0);
    step(0, 0, 0, 0, 1, 256);
    step(0, 0, 0, 0, 1, 257);
    step(0, 0, 0, 0, 1, 'h41);
    step(0, 0, 0, 0, 1, 300);
    idle();

    // Fill from a clean dictionary to full
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) step(0, 1, $urandom_range(0, 8191), $urandom_range(0, 255), 0, 0);
    step(0, 1, 77, 77, 1, 511);
    step(0, 0, 0, 0, 1, 512);
    idle();

    // Flush beats a same-cycle add; stale entries read as unassigned
    step(1, 1, 5, 6, 1, 300);
    step(0, 0, 0, 0, 1, 257);
    for (int i = 0; i < 4; i++) step(0, 1, i + 1, i + 10, 0, 0);
    step(0, 1, 'h12, 'h34, 1, 260);
    step(0, 0, 0, 0, 1, 260);

    // Asynchronous reset while a response is on the port
    step(0, 0, 0, 0, 1, 256);
    @(posedge clk);
    #3;
    rd_req = 1'b0;
    chk("pre_rst_rd_valid", int'(rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rd_valid", int'(rd_valid), 0);
    chk("async_rd_prefix", int'(rd_prefix), 0);
    chk("async_next_code", int'(next_code), FIRST);
    chk("async_full", int'(full), 0);
    ref_next = FIRST; ref_full = 0;
    last_prefix = 0; last_char = 0; last_root = 0; last_err = 0;
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) rc = ref_next;
      else if (sel == 1) rc = $urandom_range(0, 255);
      else rc = $urandom_range(FIRST, (ref_next + 8 > 8191) ? 8191 : ref_next + 8);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 8191), $urandom_range(0, 255),
           $urandom_range(0, 1), rc);
    end
    idle();
    idle();
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
